// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with load-use and branch-operand hazard detection.
// It stalls on hazards, flushes on taken branches, and keeps saturating event counters.
module if_id_hazard_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ifPc4,
  input  logic [31:0] ifInstr,
  input  logic        idexRegWrite,
  input  logic        idexMemRead,
  input  logic [4:0]  idexWriteReg,
  input  logic        exmeMemRead,
  input  logic [4:0]  exmeWriteReg,
  input  logic        branchTaken,
  output logic [31:0] idPc4,
  output logic [31:0] idInstr,
  output logic [4:0]  idRs,
  output logic [4:0]  idRt,
  output logic [5:0]  idOpcode,
  output logic        idValid,
  output logic        pcWrite,
  output logic        idBubble,
  output logic [1:0]  stageState,
  output logic [15:0] stallCount,
  output logic [15:0] flushCount
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_STALLED = 2'b01,
    ST_FLUSHED = 2'b10
  } stage_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  stage_state_e r_state;
  stage_state_e w_next_state;
  logic [31:0]  r_pc4;
  logic [31:0]  r_instr;
  logic         r_valid;
  logic [15:0]  r_stall_count;
  logic [15:0]  r_flush_count;

  logic [4:0]   w_rs;
  logic [4:0]   w_rt;
  logic [5:0]   w_opcode;
  logic         w_uses_rt;
  logic         w_is_beq;
  logic         w_load_use;
  logic         w_beq_alu;
  logic         w_beq_load;
  logic         w_hazard;

  assign w_rs     = r_instr[25:21];
  assign w_rt     = r_instr[20:16];
  assign w_opcode = r_instr[31:26];
  assign w_is_beq = (w_opcode == OP_BEQ);

  // I-type ALU ops and loads write rt, so rt is only a source for R-type, beq and sw.
  assign w_uses_rt = (w_opcode == OP_RTYPE) || (w_opcode == OP_BEQ) || (w_opcode == OP_SW);

  function automatic logic src_match(input logic [4:0] r, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  assign w_load_use = r_valid && idexMemRead && src_match(idexWriteReg, w_rs, w_rt, w_uses_rt);
  assign w_beq_alu  = r_valid && w_is_beq && idexRegWrite &&
                      src_match(idexWriteReg, w_rs, w_rt, w_uses_rt);
  assign w_beq_load = r_valid && w_is_beq && exmeMemRead &&
                      src_match(exmeWriteReg, w_rs, w_rt, w_uses_rt);
  assign w_hazard   = w_load_use || w_beq_alu || w_beq_load;

  // Hazard outranks the branch: a stalled beq must resolve with forwarded operands first.
  always_comb begin
    // NOTE: default assigned first so every path drives the signal and no latch is inferred.
    w_next_state = ST_RUN;
    if (w_hazard) begin
      w_next_state = ST_STALLED;
    end else if (branchTaken && r_valid) begin
      w_next_state = ST_FLUSHED;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_pc4         <= '0;
      r_instr       <= '0;
      r_valid       <= 1'b0;
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      r_state <= w_next_state;
      case (w_next_state)
        ST_STALLED: begin
          if (r_stall_count != CNT_MAX) r_stall_count <= r_stall_count + 16'd1;
        end
        ST_FLUSHED: begin
          r_pc4   <= '0;
          r_instr <= '0;
          r_valid <= 1'b0;
          if (r_flush_count != CNT_MAX) r_flush_count <= r_flush_count + 16'd1;
        end
        default: begin
          r_pc4   <= ifPc4;
          r_instr <= ifInstr;
          r_valid <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    pcWrite  = !w_hazard;
    idBubble = w_hazard || !r_valid;
  end

  assign idPc4      = r_pc4;
  assign idInstr    = r_instr;
  assign idRs       = w_rs;
  assign idRt       = w_rt;
  assign idOpcode   = w_opcode;
  assign idValid    = r_valid;
  assign stageState = r_state;
  assign stallCount = r_stall_count;
  assign flushCount = r_flush_count;

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Directed bench for if_id_hazard_stage: hand-encoded MIPS words drive stall,
// flush, reset and counter-saturation scenarios.
module tb_if_id_hazard_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ifPc4, ifInstr;
  logic        idexRegWrite, idexMemRead, exmeMemRead, branchTaken;
  logic [4:0]  idexWriteReg, exmeWriteReg;
  logic [31:0] idPc4, idInstr;
  logic [4:0]  idRs, idRt;
  logic [5:0]  idOpcode;
  logic        idValid, pcWrite, idBubble;
  logic [1:0]  stageState;
  logic [15:0] stallCount, flushCount;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_stall = 16'd0;
  logic [15:0] exp_flush = 16'd0;

  localparam logic [31:0] I_ADD_9_8_10  = 32'h010A4820; // add  $9,$8,$10
  localparam logic [31:0] I_ADD_9_0_10  = 32'h000A4820; // add  $9,$0,$10
  localparam logic [31:0] I_LW_8        = 32'h8C280000; // lw   $8,0($1)
  localparam logic [31:0] I_BEQ_5_6     = 32'h10A60004; // beq  $5,$6,+4
  localparam logic [31:0] I_ADDI_3_2    = 32'h20430001; // addi $3,$2,1
  localparam logic [31:0] I_SW_7        = 32'hAC270000; // sw   $7,0($1)
  localparam logic [31:0] I_OTHER       = 32'h3C0BBEEF; // lui  $11,0xBEEF

  if_id_hazard_stage dut (
    .clk(clk), .rst_n(rst_n), .ifPc4(ifPc4), .ifInstr(ifInstr),
    .idexRegWrite(idexRegWrite), .idexMemRead(idexMemRead), .idexWriteReg(idexWriteReg),
    .exmeMemRead(exmeMemRead), .exmeWriteReg(exmeWriteReg), .branchTaken(branchTaken),
    .idPc4(idPc4), .idInstr(idInstr), .idRs(idRs), .idRt(idRt), .idOpcode(idOpcode),
    .idValid(idValid), .pcWrite(pcWrite), .idBubble(idBubble), .stageState(stageState),
    .stallCount(stallCount), .flushCount(flushCount)
  );

  always #5 clk = ~clk;

  task automatic clear_downstream();
    idexRegWrite = 1'b0; idexMemRead = 1'b0; idexWriteReg = 5'd0;
    exmeMemRead  = 1'b0; exmeWriteReg = 5'd0; branchTaken = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Places an instruction into IF/ID with no downstream activity.
  task automatic load_id(input logic [31:0] pc4, input logic [31:0] instr);
    clear_downstream();
    ifPc4 = pc4; ifInstr = instr;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ifPc4 = 32'h0000_1004; ifInstr = I_OTHER;
    clear_downstream();
    #3;
    n_vec++; if (idPc4 !== 32'd0) begin n_err++; $display("FAIL reset_idPc4 got=%h exp=0", idPc4); end
    n_vec++; if (idInstr !== 32'd0) begin n_err++; $display("FAIL reset_idInstr got=%h exp=0", idInstr); end
    n_vec++; if (idValid !== 1'b0) begin n_err++; $display("FAIL reset_idValid got=%b exp=0", idValid); end
    n_vec++; if (stageState !== 2'b00) begin n_err++; $display("FAIL reset_state got=%b exp=00", stageState); end
    n_vec++; if (stallCount !== 16'd0 || flushCount !== 16'd0) begin n_err++;
      $display("FAIL reset_counts got=%h/%h exp=0/0", stallCount, flushCount); end
    n_vec++; if (pcWrite !== 1'b1 || idBubble !== 1'b1) begin n_err++;
      $display("FAIL reset_pcw_bubble got=%b%b exp=11", pcWrite, idBubble); end
    tick();
    rst_n = 1'b1;
    #1;
    load_id(32'h0000_1004, I_OTHER);
    n_vec++; if (idInstr !== I_OTHER || idPc4 !== 32'h0000_1004 || idValid !== 1'b1) begin n_err++;
      $display("FAIL first_load got=%h/%h/%b exp=%h/00001004/1", idInstr, idPc4, idValid, I_OTHER); end
    n_vec++; if (stageState !== 2'b00 || idBubble !== 1'b0) begin n_err++;
      $display("FAIL first_load_state got=%b/%b exp=00/0", stageState, idBubble); end
  endtask

  task automatic test_load_use();
    load_id(32'h0000_2004, I_ADD_9_8_10);
    n_vec++; if (idRs !== 5'd8 || idRt !== 5'd10 || idOpcode !== 6'd0) begin n_err++;
      $display("FAIL decode_fields got=%0d/%0d/%0d exp=8/10/0", idRs, idRt, idOpcode); end
    idexMemRead = 1'b1; idexRegWrite = 1'b1; idexWriteReg = 5'd8;
    ifPc4 = 32'h0000_2008; ifInstr = I_OTHER;
    #1;
    n_vec++; if (pcWrite !== 1'b0 || idBubble !== 1'b1) begin n_err++;
      $display("FAIL loaduse_comb got=%b%b exp=01", pcWrite, idBubble); end
    tick(); exp_stall++;
    n_vec++; if (idInstr !== I_ADD_9_8_10 || stageState !== 2'b01 || stallCount !== exp_stall) begin n_err++;
      $display("FAIL loaduse_hold got=%h/%b/%0d exp=%h/01/%0d", idInstr, stageState, stallCount, I_ADD_9_8_10, exp_stall); end
    clear_downstream();
    #1;
    n_vec++; if (pcWrite !== 1'b1 || idBubble !== 1'b0) begin n_err++;
      $display("FAIL loaduse_release got=%b%b exp=10", pcWrite, idBubble); end
    tick();
    n_vec++; if (idInstr !== I_OTHER || stageState !== 2'b00 || stallCount !== exp_stall) begin n_err++;
      $display("FAIL loaduse_resume got=%h/%b/%0d exp=%h/00/%0d", idInstr, stageState, stallCount, I_OTHER, exp_stall); end
  endtask

  task automatic test_beq_after_load();
    load_id(32'h0000_3004, I_BEQ_5_6);
    idexRegWrite = 1'b1; idexMemRead = 1'b1; idexWriteReg = 5'd5;
    ifInstr = I_OTHER;
    tick(); exp_stall++;
    n_vec++; if (stageState !== 2'b01 || idInstr !== I_BEQ_5_6) begin n_err++;
      $display("FAIL beqload_stall1 got=%b/%h exp=01/%h", stageState, idInstr, I_BEQ_5_6); end
    idexRegWrite = 1'b0; idexMemRead = 1'b0; idexWriteReg = 5'd0;
    exmeMemRead = 1'b1; exmeWriteReg = 5'd5;
    #1;
    n_vec++; if (pcWrite !== 1'b0) begin n_err++; $display("FAIL beqload_comb2 got=%b exp=0", pcWrite); end
    tick(); exp_stall++;
    n_vec++; if (stageState !== 2'b01 || stallCount !== exp_stall) begin n_err++;
      $display("FAIL beqload_stall2 got=%b/%0d exp=01/%0d", stageState, stallCount, exp_stall); end
    clear_downstream();
    #1;
    n_vec++; if (pcWrite !== 1'b1) begin n_err++; $display("FAIL beqload_third got=%b exp=1", pcWrite); end
    tick();
    n_vec++; if (stageState !== 2'b00 || idInstr !== I_OTHER) begin n_err++;
      $display("FAIL beqload_resume got=%b/%h exp=00/%h", stageState, idInstr, I_OTHER); end
  endtask

  task automatic test_branch_flush();
    load_id(32'h0000_4004, I_BEQ_5_6);
    branchTaken = 1'b1; ifPc4 = 32'h0000_4008; ifInstr = I_OTHER;
    tick(); exp_flush++;
    n_vec++; if (idInstr !== 32'd0 || idPc4 !== 32'd0 || idValid !== 1'b0) begin n_err++;
      $display("FAIL flush_regs got=%h/%h/%b exp=0/0/0", idInstr, idPc4, idValid); end
    n_vec++; if (stageState !== 2'b10 || flushCount !== exp_flush || idBubble !== 1'b1) begin n_err++;
      $display("FAIL flush_state got=%b/%0d/%b exp=10/%0d/1", stageState, flushCount, idBubble, exp_flush); end
    ifPc4 = 32'h0000_5004; ifInstr = I_ADD_9_0_10;
    tick();
    n_vec++; if (idInstr !== I_ADD_9_0_10 || idValid !== 1'b1 || stageState !== 2'b00 || flushCount !== exp_flush) begin n_err++;
      $display("FAIL flush_next got=%h/%b/%b/%0d exp=%h/1/00/%0d", idInstr, idValid, stageState, flushCount, I_ADD_9_0_10, exp_flush); end
    branchTaken = 1'b0;
  endtask

  task automatic test_branch_during_stall();
    load_id(32'h0000_6004, I_BEQ_5_6);
    idexRegWrite = 1'b1; idexWriteReg = 5'd6; branchTaken = 1'b1; ifInstr = I_OTHER;
    tick(); exp_stall++;
    n_vec++; if (stageState !== 2'b01 || idInstr !== I_BEQ_5_6 || flushCount !== exp_flush) begin n_err++;
      $display("FAIL brstall_noflush got=%b/%h/%0d exp=01/%h/%0d", stageState, idInstr, flushCount, I_BEQ_5_6, exp_flush); end
    idexRegWrite = 1'b0; idexWriteReg = 5'd0;
    tick(); exp_flush++;
    n_vec++; if (stageState !== 2'b10 || idValid !== 1'b0 || flushCount !== exp_flush || stallCount !== exp_stall) begin n_err++;
      $display("FAIL brstall_flush got=%b/%b/%0d/%0d exp=10/0/%0d/%0d", stageState, idValid, flushCount, stallCount, exp_flush, exp_stall); end
    branchTaken = 1'b0;
  endtask

  task automatic test_zero_and_rt();
    load_id(32'h0000_7004, I_ADD_9_0_10);
    idexMemRead = 1'b1; idexRegWrite = 1'b1; idexWriteReg = 5'd0;
    #1;
    n_vec++; if (pcWrite !== 1'b1) begin n_err++; $display("FAIL zero_reg got=%b exp=1", pcWrite); end
    load_id(32'h0000_7008, I_ADDI_3_2);
    idexMemRead = 1'b1; idexRegWrite = 1'b1; idexWriteReg = 5'd3;
    #1;
    n_vec++; if (pcWrite !== 1'b1) begin n_err++; $display("FAIL addi_rt_only got=%b exp=1", pcWrite); end
    idexWriteReg = 5'd2;
    #1;
    n_vec++; if (pcWrite !== 1'b0) begin n_err++; $display("FAIL addi_rs got=%b exp=0", pcWrite); end
    load_id(32'h0000_700C, I_SW_7);
    idexMemRead = 1'b1; idexWriteReg = 5'd7;
    #1;
    n_vec++; if (pcWrite !== 1'b0) begin n_err++; $display("FAIL sw_rt got=%b exp=0", pcWrite); end
    exmeMemRead = 1'b1; exmeWriteReg = 5'd7; idexMemRead = 1'b0;
    #1;
    n_vec++; if (pcWrite !== 1'b1) begin n_err++; $display("FAIL exme_nonbeq got=%b exp=1", pcWrite); end
    clear_downstream();
  endtask

  task automatic test_reset_mid_stall();
    load_id(32'h0000_8004, I_ADD_9_8_10);
    idexMemRead = 1'b1; idexWriteReg = 5'd8; ifInstr = I_OTHER;
    tick(); exp_stall++;
    n_vec++; if (stageState !== 2'b01 || stallCount !== exp_stall) begin n_err++;
      $display("FAIL midstall_pre got=%b/%0d exp=01/%0d", stageState, stallCount, exp_stall); end
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (idInstr !== 32'd0 || idValid !== 1'b0 || stageState !== 2'b00 || stallCount !== 16'd0 || flushCount !== 16'd0) begin n_err++;
      $display("FAIL async_reset got=%h/%b/%b/%0d/%0d exp=0/0/00/0/0", idInstr, idValid, stageState, stallCount, flushCount); end
    n_vec++; if (pcWrite !== 1'b1 || idBubble !== 1'b1) begin n_err++;
      $display("FAIL async_reset_ctl got=%b%b exp=11", pcWrite, idBubble); end
    exp_stall = 16'd0; exp_flush = 16'd0;
    tick();
    rst_n = 1'b1;
    #1;
    tick();
    n_vec++; if (stageState !== 2'b00 || idInstr !== I_OTHER || idValid !== 1'b1) begin n_err++;
      $display("FAIL reset_resume got=%b/%h/%b exp=00/%h/1", stageState, idInstr, idValid, I_OTHER); end
    clear_downstream();
  endtask

  task automatic test_saturation();
    load_id(32'h0000_9004, I_ADD_9_8_10);
    idexMemRead = 1'b1; idexWriteReg = 5'd8;
    repeat (65534) @(posedge clk);
    #1;
    n_vec++; if (stallCount !== 16'hFFFE) begin n_err++; $display("FAIL sat_near got=%h exp=fffe", stallCount); end
    tick();
    n_vec++; if (stallCount !== 16'hFFFF) begin n_err++; $display("FAIL sat_reach got=%h exp=ffff", stallCount); end
    repeat (4) @(posedge clk);
    #1;
    n_vec++; if (stallCount !== 16'hFFFF || stageState !== 2'b01) begin n_err++;
      $display("FAIL sat_hold got=%h/%b exp=ffff/01", stallCount, stageState); end
    clear_downstream();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_beq_after_load();
    test_branch_flush();
    test_branch_during_stall();
    test_zero_and_rt();
    test_reset_mid_stall();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
